// File: rtl/life_pkg.sv
// Shared constants, FSM state type and address mapping for the life-grid cell plane.
package life_pkg;

    localparam int GRID_W = 160;
    localparam int GRID_H = 120;
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int AW     = 15;
    localparam int XW     = 8;
    localparam int YW     = 7;

    typedef logic [AW-1:0] addr_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WRITE2
    } state_t;

    // Row-major cell index y*160 + x built from two shifts and an add.
    function automatic addr_t cell_addr(input logic [XW-1:0] cx, input logic [YW-1:0] cy);
        addr_t yy;
        yy = addr_t'(cy);
        return (yy << 7) + (yy << 5) + addr_t'(cx);
    endfunction

endpackage

// File: rtl/cell_ram.sv
// One-bit-per-cell RAM: one write port, two registered read ports, read-before-write.
module cell_ram
    import life_pkg::*;
#(
    parameter int DEPTH = CELLS
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] a_addr,
    output logic          a_q,
    input  logic [AW-1:0] b_addr,
    output logic          b_q
);

    logic mem [0:DEPTH-1];

    // Write and both reads share one edge; reads see the contents before this write.
    // NOTE: the array has no reset so it maps onto block RAM; the clear sweep initialises it.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        a_q <= mem[a_addr];
        b_q <= mem[b_addr];
    end

endmodule

// File: rtl/cell_plane.sv
// Bit-per-cell store of the life grid: plot-stream writes, cell read-back, live-cell count.
module cell_plane
    import life_pkg::*;
#(
    parameter int GRID_W = life_pkg::GRID_W,
    parameter int GRID_H = life_pkg::GRID_H,
    parameter int XW     = life_pkg::XW,
    parameter int YW     = life_pkg::YW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [2:0]    colour,
    input  logic          plot,
    output logic          ready,
    input  logic          rd_en,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic          rd_valid,
    output logic          rd_alive,
    output logic [14:0]   live_count,
    output logic          busy,
    output logic          oob_err
);

    localparam logic [XW-1:0] X_LIM = XW'(GRID_W);
    localparam logic [YW-1:0] Y_LIM = YW'(GRID_H);
    localparam addr_t         LAST  = addr_t'(GRID_W * GRID_H - 1);

    state_t state;
    addr_t  sw_addr;
    addr_t  wr_addr;
    logic   wr_bit;
    logic   rd_hit;

    logic   wr_ok;
    logic   rd_ok;
    addr_t  a_addr;
    addr_t  b_addr;
    logic   a_q;
    logic   b_q;
    logic   ram_we;
    addr_t  ram_waddr;
    logic   ram_wdata;

    // Range checks; out-of-range coordinates are steered to address 0 so the RAM is never over-indexed.
    assign wr_ok  = (x < X_LIM) && (y < Y_LIM);
    assign rd_ok  = (rd_x < X_LIM) && (rd_y < Y_LIM);
    assign a_addr = wr_ok ? cell_addr(x, y) : '0;
    assign b_addr = rd_ok ? cell_addr(rd_x, rd_y) : '0;

    // Write port: sweep zeros in CLEAR, commit the latched bit in WRITE2; a write coinciding with reset is dropped.
    // NOTE: every output of this always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sw_addr;
        ram_wdata = 1'b0;
        if (!reset) begin
            if (state == CLEAR) begin
                ram_we = 1'b1;
            end else if (state == WRITE2) begin
                ram_we    = 1'b1;
                ram_waddr = wr_addr;
                ram_wdata = wr_bit;
            end
        end
    end

    cell_ram u_ram (
        .clock  (clock),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .a_addr (a_addr),
        .a_q    (a_q),
        .b_addr (b_addr),
        .b_q    (b_q)
    );

    // Control FSM with sweep counter, live counter, sticky range error and registered handshake outputs.
    // NOTE: state registers use non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CLEAR;
            sw_addr    <= '0;
            wr_addr    <= '0;
            wr_bit     <= 1'b0;
            live_count <= '0;
            oob_err    <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    sw_addr <= sw_addr + 1'b1;
                    if (sw_addr == LAST) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state      <= CLEAR;
                        sw_addr    <= '0;
                        live_count <= '0;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                    end else if (plot) begin
                        if (wr_ok) begin
                            state   <= WRITE2;
                            ready   <= 1'b0;
                            wr_addr <= a_addr;
                            wr_bit  <= |colour;
                        end else begin
                            oob_err <= 1'b1;
                        end
                    end
                end
                WRITE2: begin
                    // a_q holds the old bit read during acceptance.
                    case ({a_q, wr_bit})
                        2'b01:   live_count <= live_count + 1'b1;
                        2'b10:   live_count <= live_count - 1'b1;
                        default: live_count <= live_count;
                    endcase
                    if (clear) begin
                        state      <= CLEAR;
                        sw_addr    <= '0;
                        live_count <= '0;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    sw_addr <= '0;
                    ready   <= 1'b0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    // Read-back qualifiers; reads are ignored during the clear sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
        end else begin
            rd_valid <= rd_en && (state != CLEAR);
            rd_hit   <= rd_en && (state != CLEAR) && rd_ok;
        end
    end

    assign rd_alive = b_q & rd_hit;

endmodule

// File: tb/tb_cell_plane.sv
// Directed bench for cell_plane: read responses are scoreboarded, control outputs checked inline.
module tb_cell_plane;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        ready;
    logic        rd_en;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_valid;
    logic        rd_alive;
    logic [14:0] live_count;
    logic        busy;
    logic        oob_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];
    bit mon_exp;

    cell_plane dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .ready      (ready),
        .rd_en      (rd_en),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .rd_alive   (rd_alive),
        .live_count (live_count),
        .busy       (busy),
        .oob_err    (oob_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic plot_cell(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        wait_ready();
        x = px; y = py; colour = pc; plot = 1'b1;
        step();
        plot = 1'b0;
    endtask

    task automatic read_cell(input logic [7:0] rx, input logic [6:0] ry, input bit exp);
        rd_x = rx; rd_y = ry; rd_en = 1'b1;
        exp_q.push_back(exp);
        step();
        rd_en = 1'b0;
    endtask

    // Counts cycles with ready low after entering CLEAR; optionally issues reads that must be ignored.
    task automatic sweep_wait(input string name, input bit with_reads);
        int n = 0;
        bit busy_drop = 0;
        while (ready !== 1'b1 && n < 25000) begin
            if (busy !== 1'b1) busy_drop = 1;
            rd_en = with_reads && (n < 6);
            rd_x = 8'(n); rd_y = 7'd0;
            if (with_reads && n == 3) check({name, "_rd_valid"}, 32'(rd_valid), 32'd0);
            step();
            n++;
        end
        rd_en = 1'b0;
        check({name, "_len"}, 32'(n), 32'd19200);
        check({name, "_busy_held"}, 32'(busy_drop), 32'd0);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_live"}, 32'(live_count), 32'd0);
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest expected read.
    always @(negedge clock) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_alive", 32'(rd_alive), 32'(mon_exp));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; plot = 1'b0; rd_en = 1'b0;
        x = '0; y = '0; colour = '0; rd_x = '0; rd_y = '0;
        step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_alive", 32'(rd_alive), 32'd0);
        check("rst_live", 32'(live_count), 32'd0);
        check("rst_oob", 32'(oob_err), 32'd0);
        sweep_wait("sweep_rst", 1'b0);
        read_cell(8'd0, 7'd0, 1'b0);

        // First plot: ready drops for one cycle, count lands at end of WRITE2.
        plot_cell(8'd5, 7'd7, 3'd3);
        check("plot_ready_drop", 32'(ready), 32'd0);
        check("plot_live_early", 32'(live_count), 32'd0);
        step();
        check("plot_ready_back", 32'(ready), 32'd1);
        check("plot_live", 32'(live_count), 32'd1);
        read_cell(8'd5, 7'd7, 1'b1);

        plot_cell(8'd5, 7'd7, 3'd3);
        step();
        check("replot_live", 32'(live_count), 32'd1);
        plot_cell(8'd5, 7'd7, 3'd0);
        step();
        check("kill_live", 32'(live_count), 32'd0);
        read_cell(8'd5, 7'd7, 1'b0);

        // Out-of-range writes: accepted without a ready drop, sticky error.
        plot_cell(8'd160, 7'd0, 3'd1);
        check("oob_x_ready", 32'(ready), 32'd1);
        check("oob_x_err", 32'(oob_err), 32'd1);
        plot_cell(8'd0, 7'd120, 3'd1);
        check("oob_y_ready", 32'(ready), 32'd1);
        check("oob_live", 32'(live_count), 32'd0);
        plot_cell(8'd1, 7'd1, 3'd2);
        step();
        check("oob_sticky", 32'(oob_err), 32'd1);
        check("live_1_1", 32'(live_count), 32'd1);

        // Same-cycle plot and read of the corner cell returns the old value; read in WRITE2 is honoured.
        wait_ready();
        x = 8'd159; y = 7'd119; colour = 3'd4; plot = 1'b1;
        rd_x = 8'd159; rd_y = 7'd119; rd_en = 1'b1;
        exp_q.push_back(1'b0);
        step();
        plot = 1'b0; rd_en = 1'b0;
        read_cell(8'd1, 7'd1, 1'b1);
        check("corner_live", 32'(live_count), 32'd2);
        read_cell(8'd159, 7'd119, 1'b1);
        read_cell(8'd200, 7'd5, 1'b0);
        read_cell(8'd3, 7'd127, 1'b0);

        // Ten writes, clear raised during WRITE2 of the tenth.
        for (int i = 0; i < 10; i++) begin
            plot_cell(8'(10 + i), 7'd20, 3'((i % 7) + 1));
            if (i == 8) begin
                step();
                check("live_before_clear", 32'(live_count), 32'd11);
            end
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_ready", 32'(ready), 32'd0);
        check("clr_live", 32'(live_count), 32'd0);
        sweep_wait("sweep_clr", 1'b1);
        for (int i = 0; i < 10; i++) read_cell(8'(10 + i), 7'd20, 1'b0);
        read_cell(8'd159, 7'd119, 1'b0);
        read_cell(8'd1, 7'd1, 1'b0);

        // Clear and plot together in IDLE: clear wins.
        wait_ready();
        clear = 1'b1; plot = 1'b1; x = 8'd2; y = 7'd2; colour = 3'd1;
        step();
        clear = 1'b0; plot = 1'b0;
        check("clrplot_busy", 32'(busy), 32'd1);
        sweep_wait("sweep_clrplot", 1'b0);
        read_cell(8'd2, 7'd2, 1'b0);

        step();
        step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_plane.md
# cell_plane

Bit-per-cell store for the 160x120 life grid that receives the plot stream (x, y, colour, plot) produced by the simulation and control path and serves cell read-back. Any non-zero colour marks a cell alive. The block keeps a running live-cell count and clears itself after reset. It sits alongside the VGA adapter on the same plot bus and gives the simulation a registered, queryable copy of what was drawn.

## Interface
Parameters:
- GRID_W, 160, cells per row
- GRID_H, 120, rows
- XW, 8, x coordinate width
- YW, 7, y coordinate width

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- clear  in  1  pulse; starts a full clear sweep
- x  in  XW  plot column
- y  in  YW  plot row
- colour  in  3  plot colour; alive = |colour
- plot  in  1  write request
- ready  out  1  write is accepted when plot && ready
- rd_en  in  1  read request
- rd_x  in  XW  read column
- rd_y  in  YW  read row
- rd_valid  out  1  read data valid
- rd_alive  out  1  cell state for the read
- live_count  out  15  number of alive cells, 0..19200
- busy  out  1  clear sweep in progress
- oob_err  out  1  sticky; set when an out-of-range write is accepted

## Operation
- Address mapping: addr = y*160 + x, computed as (y<<7) + (y<<5) + x, 15 bits. No multiplier.
- FSM states:
  - CLEAR: writes 0 at sweep address sw_addr, then increments it. Leaves for IDLE after sw_addr = 19199 is written. ready=0, busy=1.
  - IDLE: ready=1. An accepted in-range write moves to WRITE2 (cycle 1 of the read-modify-write, RMW). clear=1 moves to CLEAR with sw_addr=0 and live_count=0. If clear and plot occur in the same cycle, clear wins and the plot is not accepted (ready is treated as 0).
  - WRITE2: the old bit is available. Write the new bit. Update live_count: +1 on 0->1, -1 on 1->0, unchanged otherwise. ready=0. Next state is IDLE, or CLEAR if clear was sampled high in WRITE2.
- Out-of-range write (x >= 160 or y >= 120): accepted in IDLE, memory unchanged, oob_err set to 1, FSM stays in IDLE. oob_err is cleared only by reset.
- Reads:
  - rd_en is honoured in IDLE and WRITE2 and ignored in CLEAR.
  - An out-of-range read returns rd_alive=0 with rd_valid=1.
  - Read and write to the same cell in the same cycle: the read returns the old value.
- Reset mid-operation: an in-flight write is dropped, the FSM enters CLEAR with sw_addr=0, and live_count becomes 0.

## Timing
- Reset values: ready=0, busy=1, rd_valid=0, rd_alive=0, live_count=0, oob_err=0, state=CLEAR, sw_addr=0.
- Clear sweep: 19200 cycles. busy falls and ready rises on the cycle after the write of address 19199.
- Write throughput: one write per 2 cycles. ready is low for exactly one cycle after each accepted in-range write.
- live_count reflects a write on the clock edge ending WRITE2, i.e. 2 cycles after acceptance.
- Read latency: 1 cycle. rd_valid and rd_alive are registered and asserted on the cycle after rd_en. Back-to-back reads are allowed every cycle.
- rd_valid is 0 on any cycle following a cycle with no honoured read.

## Structure
- Package life_pkg holds:
  - GRID_W, GRID_H, CELLS=19200
  - the 15-bit address width
  - the FSM state enum (CLEAR, IDLE, WRITE2)
  - the cell_addr function (shift-add mapping)
- Sub-module cell_ram: 19200x1 simple dual-port RAM with one write port and two registered read ports (RMW port, query port), read-before-write. It is inferable as block RAM.
- Top level holds the FSM, sweep counter, live counter, range checks and oob flag.

## Test plan
- Reset for 1 cycle -> busy=1, ready=0 for exactly 19200 cycles, then ready=1, busy=0, live_count=0. A read of (0,0) returns rd_alive=0.
- Plot (5,7, colour=3) -> ready low the next cycle. live_count=1 two cycles after acceptance. Read (5,7) gives rd_valid=1, rd_alive=1 one cycle after rd_en.
- Replot (5,7) colour=3 -> live_count stays 1. Replot colour=0 -> live_count=0 and read (5,7) gives rd_alive=0.
- Plot (160,0) then plot (0,120) -> oob_err=1, live_count unchanged, no ready drop. oob_err still 1 after a later valid write.
- Plot (159,119) and read (159,119) in the same cycle -> rd_alive=0 (old value). A read on the next idle cycle gives 1, and live_count increments.
- Write 10 cells, then assert clear during WRITE2 of the 10th -> the 10th write completes, CLEAR is entered with live_count=0, busy holds for 19200 cycles, reads during the sweep produce rd_valid=0, and all 10 cells read 0 afterwards.
